// File: rtl/key_event_pkg.sv
// Shared types and constants for the key gesture decoder.
// State encoding, ms timebase derivation and counter width.
package key_event_pkg;

    localparam int MS_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } kev_state_e;

    function automatic int cyc_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle ms_tick_o on terminal count.
// clr_i restarts the count so a new interval starts from zero.
module ms_tick_gen
    import key_event_pkg::*;
#(
    parameter int CYC_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic ms_tick_o
);

    localparam int            PW = cnt_w(CYC_PER_MS);
    localparam logic [PW-1:0] TC = PW'(CYC_PER_MS - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign ms_tick_o = (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clr_i || ms_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short, double and long presses.
// Define KEY_EVENT_REPEAT_EN to add auto-repeat pulses while held.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int LONG_MS     = 1000,
    parameter int DBL_MS      = 300,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_press,
    input  logic key_release,
    output logic evt_short,
    output logic evt_double,
    output logic evt_long,
    output logic evt_repeat,
    output logic busy
);

    localparam int              CYC_PER_MS = cyc_per_ms(CLK_FREQ_HZ);
    localparam logic [MS_W-1:0] LONG_LIM   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] DBL_LIM    = MS_W'(DBL_MS - 1);
    localparam logic [MS_W-1:0] REP_LIM    = MS_W'(REPEAT_MS - 1);

    kev_state_e      state_q, state_d;
    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0] lim;
    logic            ms_tick;
    logic            clr;
    logic            expire;
    logic            press, rel;
    logic            short_q, short_d;
    logic            dbl_q, dbl_d;
    logic            long_q, long_d;
`ifdef KEY_EVENT_REPEAT_EN
    logic            rep_q, rep_d;
`endif

    // Coincident press and release cancel each other out.
    assign press = key_press & ~key_release;
    assign rel   = key_release & ~key_press;

    ms_tick_gen #(
        .CYC_PER_MS (CYC_PER_MS)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .ms_tick_o (ms_tick)
    );

    always_comb begin
        lim = LONG_LIM;
        case (state_q)
            WAIT2:     lim = DBL_LIM;
            LONG_HELD: lim = REP_LIM;
            default:   lim = LONG_LIM;
        endcase
    end

    // Timeout fires on the tick that would bring ms_cnt up to the limit.
    assign expire = ms_tick && (ms_cnt_q == lim);

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        rep_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (press) state_d = PRESS1;
            end
            PRESS1: begin
                if (rel) begin
                    state_d = WAIT2;
                end else if (expire) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (press) begin
                    state_d = PRESS2;
                end else if (expire) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (rel) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end else if (expire) begin
                    state_d = LONG_HELD;
                    dbl_d   = 1'b1;
                end
            end
            LONG_HELD: begin
                if (rel) begin
                    state_d = IDLE;
`ifdef KEY_EVENT_REPEAT_EN
                end else if (expire) begin
                    rep_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_EVENT_REPEAT_EN
    assign clr = (state_d != state_q) || rep_d;
`else
    assign clr = (state_d != state_q);
`endif

    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (clr) begin
            ms_cnt_d = '0;
        end else if (ms_tick && (ms_cnt_q != '1)) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            short_q  <= 1'b0;
            dbl_q    <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            short_q  <= short_d;
            dbl_q    <= dbl_d;
            long_q   <= long_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign evt_repeat = rep_q;
`else
    assign evt_repeat = 1'b0;
`endif

    assign evt_short  = short_q;
    assign evt_double = dbl_q;
    assign evt_long   = long_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: gesture vector table, hand sequences
// and random key activity against a time-in-state reference model.
module tb_key_event_decoder;

    localparam int CLK_HZ = 10000;
    localparam int CPM    = 10;
    localparam int LONG   = 20;
    localparam int DBL    = 5;
    localparam int REP    = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_press = 1'b0;
    logic key_release = 1'b0;
    logic evt_short, evt_double, evt_long, evt_repeat, busy;

    key_event_decoder #(
        .CLK_FREQ_HZ (CLK_HZ),
        .LONG_MS     (LONG),
        .DBL_MS      (DBL),
        .REPEAT_MS   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_press   (key_press),
        .key_release (key_release),
        .evt_short   (evt_short),
        .evt_double  (evt_double),
        .evt_long    (evt_long),
        .evt_repeat  (evt_repeat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int gc = 0;
    int lc = 0;

    typedef enum int {M_IDLE, M_P1, M_W2, M_P2, M_LH} ph_e;
    ph_e        m_ph;
    int         m_entry;
    logic [3:0] m_exp;

    int   first_s, first_d, first_l;
    int   n_s, n_d, n_l, n_r, bfall;
    logic prev_busy;

    typedef struct {
        string nm;
        int p0, r0, p1, r1, len;
        int es, ed, el, er, bf, be;
    } vec_t;
    vec_t vecs[6];

    function automatic vec_t mk(input string nm,
                                input int p0, input int r0,
                                input int p1, input int r1,
                                input int len, input int es,
                                input int ed, input int el,
                                input int er, input int bf,
                                input int be);
        vec_t v;
        v.nm = nm; v.p0 = p0; v.r0 = r0; v.p1 = p1; v.r1 = r1;
        v.len = len; v.es = es; v.ed = ed; v.el = el;
        v.er = er; v.bf = bf; v.be = be;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clear_rec();
        first_s = -1; first_d = -1; first_l = -1;
        n_s = 0; n_d = 0; n_l = 0; n_r = 0;
        bfall = -1; prev_busy = 1'b0; lc = 0;
    endtask

    task automatic model_reset();
        m_ph = M_IDLE;
        m_entry = gc;
        m_exp = '0;
    endtask

    // Timeouts measured as cycles spent in the current phase.
    task automatic model_step(input logic p, input logic r);
        logic pr, rl;
        int   n;
        ph_e  nx;
        pr = p && !r;
        rl = r && !p;
        n = gc - m_entry + 1;
        nx = m_ph;
        m_exp = '0;
        case (m_ph)
            M_IDLE: if (pr) nx = M_P1;
            M_P1: begin
                if (rl) nx = M_W2;
                else if (n == LONG * CPM) begin
                    nx = M_LH; m_exp[1] = 1'b1;
                end
            end
            M_W2: begin
                if (pr) nx = M_P2;
                else if (n == DBL * CPM) begin
                    nx = M_IDLE; m_exp[3] = 1'b1;
                end
            end
            M_P2: begin
                if (rl) begin
                    nx = M_IDLE; m_exp[2] = 1'b1;
                end else if (n == LONG * CPM) begin
                    nx = M_LH; m_exp[2] = 1'b1;
                end
            end
            M_LH: begin
                if (rl) nx = M_IDLE;
                else if (REP_EN && n == REP * CPM) begin
                    m_exp[0] = 1'b1;
                    m_entry = gc + 1;
                end
            end
            default: nx = M_IDLE;
        endcase
        if (nx != m_ph) m_entry = gc + 1;
        m_ph = nx;
    endtask

    task automatic tick(input logic p, input logic r);
        key_press = p;
        key_release = r;
        @(negedge clk);
        check($sformatf("model_cyc%0d", gc),
              int'({evt_short, evt_double, evt_long, evt_repeat, busy}),
              int'({m_exp, m_ph != M_IDLE}));
        if (evt_short) begin n_s++; if (first_s < 0) first_s = lc; end
        if (evt_double) begin n_d++; if (first_d < 0) first_d = lc; end
        if (evt_long) begin n_l++; if (first_l < 0) first_l = lc; end
        if (evt_repeat) n_r++;
        if (prev_busy && !busy && bfall < 0) bfall = lc;
        prev_busy = busy;
        model_step(p, r);
        lc++;
        gc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        key_press = 1'b0;
        key_release = 1'b0;
        #1;
        check("reset_outs",
              int'({evt_short, evt_double, evt_long, evt_repeat, busy}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_rec();
    endtask

    initial begin
        vecs[0] = mk("short",   0, 30, -1, -1, 120,  81, -1, -1, 0,  81, 0);
        vecs[1] = mk("double",  0, 30, 60, 90, 150,  -1, 91, -1, 0,  91, 0);
        vecs[2] = mk("gap",     0, 30, 85, -1, 150,  81, -1, -1, 0,  81, 1);
        vecs[3] = mk("long",    0, 500, -1, -1, 560, -1, -1, 201,
                     REP_EN ? 7 : 0, 501, 0);
        vecs[4] = mk("bound",   0, 200, -1, -1, 300, 251, -1, -1, 0, 251, 0);
        vecs[5] = mk("p2_long", 0, 30, 60, -1, 300,  -1, 261, -1, 0, -1, 1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int c = 0; c < vecs[i].len; c++) begin
                tick(c == vecs[i].p0 || c == vecs[i].p1,
                     c == vecs[i].r0 || c == vecs[i].r1);
            end
            check({vecs[i].nm, "_short_at"}, first_s, vecs[i].es);
            check({vecs[i].nm, "_short_n"}, n_s, vecs[i].es >= 0 ? 1 : 0);
            check({vecs[i].nm, "_dbl_at"}, first_d, vecs[i].ed);
            check({vecs[i].nm, "_dbl_n"}, n_d, vecs[i].ed >= 0 ? 1 : 0);
            check({vecs[i].nm, "_long_at"}, first_l, vecs[i].el);
            check({vecs[i].nm, "_long_n"}, n_l, vecs[i].el >= 0 ? 1 : 0);
            check({vecs[i].nm, "_rep_n"}, n_r, vecs[i].er);
            check({vecs[i].nm, "_busy_fall"}, bfall, vecs[i].bf);
            check({vecs[i].nm, "_busy_end"}, int'(busy), vecs[i].be);
        end

        // Coincident pulses and a stray release leave IDLE untouched.
        do_reset();
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b0);
        check("simul_idle_busy", int'(busy), 0);
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        check("stray_rel_busy", int'(busy), 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        check("simul_p1_busy", int'(busy), 1);

        // Reset while waiting for a second press.
        do_reset();
        tick(1'b1, 1'b0);
        repeat (29) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (20) tick(1'b0, 1'b0);
        check("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outs",
              int'({evt_short, evt_double, evt_long, evt_repeat, busy}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_rec();
        repeat (80) tick(1'b0, 1'b0);
        check("mid_no_short", n_s, 0);

        // Random key activity with holds long enough to reach LONG_HELD.
        do_reset();
        begin
            bit down;
            logic p, r;
            down = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                p = 1'b0;
                r = 1'b0;
                if (!down) begin
                    if ($urandom_range(0, 39) == 0) begin
                        p = 1'b1; down = 1'b1;
                    end
                end else if ($urandom_range(0, 179) == 0) begin
                    r = 1'b1; down = 1'b0;
                end
                if ($urandom_range(0, 149) == 0) begin
                    if ($urandom_range(0, 1) == 0) p = 1'b1;
                    else r = 1'b1;
                end
                if ($urandom_range(0, 299) == 0) begin
                    p = 1'b1; r = 1'b1;
                end
                tick(p, r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced press/release edge pulses from the key debouncer and classifies each gesture as short press, double click or long press.
- With the optional feature compiled in, it also emits auto-repeat pulses while a long press is held.
- Sits between the debouncer and the LED mode/brightness control logic; all outputs are single-cycle pulses.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; CYC_PER_MS = CLK_FREQ_HZ/1000 (integer).
LONG_MS, 1000, hold time in ms that qualifies a long press.
DBL_MS, 300, max gap in ms between first release and second press for a double click.
REPEAT_MS, 200, auto-repeat period in ms (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
key_press  in  1  one-cycle pulse: debounced key pressed (1->0 edge)
key_release  in  1  one-cycle pulse: debounced key released (0->1 edge)
evt_short  out  1  one-cycle pulse: single short click
evt_double  out  1  one-cycle pulse: double click
evt_long  out  1  one-cycle pulse: long press reached
evt_repeat  out  1  one-cycle pulse: auto-repeat tick (tied 0 without the optional feature)
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: all evt_* = 0, busy = 0, FSM = IDLE, ms counter = 0, prescaler = 0.
- Timebase:
  - Prescaler counts 0..CYC_PER_MS-1 and produces ms_tick on terminal count.
  - Prescaler and ms_cnt (16 bit, saturating) both clear on every FSM state change, so each timeout is exact: it fires after T*CYC_PER_MS cycles in the state.
- FSM states and transitions:
  - IDLE: key_press -> PRESS1.
  - PRESS1: key_release -> WAIT2. ms_cnt reaches LONG_MS -> LONG_HELD and fire evt_long.
  - WAIT2: key_press -> PRESS2. ms_cnt reaches DBL_MS -> IDLE and fire evt_short.
  - PRESS2: key_release -> IDLE and fire evt_double. ms_cnt reaches LONG_MS -> LONG_HELD and fire evt_double (no evt_long).
  - LONG_HELD: key_release -> IDLE.
- Output timing: evt_* are registered; each pulse is high for exactly one cycle, in the cycle after the transition decision. At most one evt_* is high in any cycle.
- Event priority within a cycle: an input pulse beats a timeout expiring in the same cycle.
  - Example: release in PRESS1 on the same cycle LONG_MS expires -> WAIT2, no evt_long.
- Simultaneous key_press and key_release in the same cycle: both ignored, state unchanged.
- Stray pulses are ignored without error:
  - key_release in IDLE or WAIT2;
  - key_press in PRESS1, PRESS2 or LONG_HELD.
- busy is combinational from the state register (state != IDLE).
- Reset mid-gesture: immediate return to IDLE; no event is emitted.

Optional Feature:
KEY_EVENT_REPEAT_EN
- Defined: in LONG_HELD, evt_repeat pulses every REPEAT_MS ms.
  - First repeat fires REPEAT_MS after evt_long.
  - ms_cnt clears on each repeat.
  - Release stops repeats immediately; a repeat expiring on the release cycle is suppressed.
- Undefined: evt_repeat is tied to 0 and the repeat counter logic is absent.

Decomposition:
- Package key_event_pkg holds:
  - the state encoding (IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG_HELD=4; 3 bits);
  - the CYC_PER_MS derivation;
  - the ms counter width constant (16).
- One sub-module: ms_tick_gen, the prescaler with a synchronous clear input and ms_tick output, instantiated once.

Test Plan:
All runs use CLK_FREQ_HZ=10000 (10 cycles/ms), LONG_MS=20, DBL_MS=5, REPEAT_MS=4.
- Short click: press at cycle 0, release at cycle 30 -> evt_short single pulse at cycle 30+50+1; no other events.
- Double click: press at 0, release at 30, press at 60, release at 90 -> evt_double at 91; evt_short never fires.
- Gap too long: press at 0, release at 30, press at 85 -> evt_short at 81; second press starts a new PRESS1 and busy stays 1.
- Long press: press at 0, hold -> evt_long at 201; release at 500 -> busy drops at 501, no further events.
  - With KEY_EVENT_REPEAT_EN: evt_repeat at 241, 281, ... 481.
- Boundary: release on exactly the cycle LONG_MS expires -> no evt_long; FSM goes to WAIT2 (evt_short follows 50 cycles later).
- Robustness: simultaneous press+release in IDLE -> no state change; assert rst_n low during WAIT2 -> all outputs 0, no evt_short after reset release.
